// File: rtl/mmio_slot_ctrl_pkg.sv
// Shared types and constants for the MMIO slot controller.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLAVE   = 2'b01;
  localparam logic [1:0] ERR_DECODE  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/mmio_slot_ctrl_if.sv
// Slot-side MMIO handshake bundle; the controller is the master.
interface mmio_slot_ctrl_if;
  import mmio_pkg::*;

  logic                chip_select;
  logic                read;
  logic                write;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wr_data;
  logic                transaction_completed;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_done;
  logic                rd_done;
  logic                slave_error;
  logic                decode_error;

  modport master (
    output chip_select, read, write, addr, wr_data, transaction_completed,
    input  rd_data, wr_done, rd_done, slave_error, decode_error
  );

  modport slave (
    input  chip_select, read, write, addr, wr_data, transaction_completed,
    output rd_data, wr_done, rd_done, slave_error, decode_error
  );
endinterface

// File: rtl/mmio_slot_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after i_last wins.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_index
);

  logic          w_found;
  logic [IW-1:0] w_pos;

  // Scan from i_last+1 around the ring; the first hit is latched via w_found.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_pos = IW'((32'(i_last) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_index        = w_pos;
      end
    end
  end

endmodule

// File: rtl/mmio_slot_ctrl.sv
// Shares one MMIO slot between NUM_REQ requesters with round-robin arbitration.
module mmio_slot_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_err,
  mmio_slot_ctrl_if.master          slot
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_idx;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IW-1:0]      w_arb_idx;
  logic               w_end;
  logic [1:0]         w_code;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .i_req   (req),
    .i_last  (r_ptr),
    .o_grant (w_arb_gnt),
    .o_index (w_arb_idx)
  );

  // Next state, slot strobes and response outputs; end-condition priority is decode > slave > done > timeout.
  always_comb begin
    w_next                     = r_state;
    w_end                      = 1'b0;
    w_code                     = ERR_OK;
    gnt                        = '0;
    rsp_valid                  = '0;
    rsp_rdata                  = '0;
    rsp_err                    = ERR_OK;
    slot.chip_select           = 1'b0;
    slot.read                  = 1'b0;
    slot.write                 = 1'b0;
    slot.addr                  = '0;
    slot.wr_data               = '0;
    slot.transaction_completed = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          gnt    = w_arb_gnt;
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        slot.chip_select = 1'b1;
        slot.read        = ~r_write;
        slot.write       = r_write;
        slot.addr        = r_addr;
        slot.wr_data     = r_wdata;
        if (slot.decode_error) begin
          w_end  = 1'b1;
          w_code = ERR_DECODE;
        end else if (slot.slave_error) begin
          w_end  = 1'b1;
          w_code = ERR_SLAVE;
        end else if (slot.wr_done || slot.rd_done) begin
          w_end  = 1'b1;
          w_code = ERR_OK;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_end  = 1'b1;
          w_code = ERR_TIMEOUT;
        end
        if (w_end) w_next = COMPLETE;
      end
      COMPLETE: begin
        slot.transaction_completed = 1'b1;
        rsp_valid[r_idx]           = 1'b1;
        rsp_rdata                  = r_rdata;
        rsp_err                    = r_err;
        w_next                     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register plus capture of the granted request and the access result.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_idx   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_idx   <= w_arb_idx;
            r_ptr   <= w_arb_idx;
            r_write <= req_write[w_arb_idx];
            r_addr  <= req_addr[w_arb_idx*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[w_arb_idx*DATA_W +: DATA_W];
            r_cnt   <= '0;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_end) begin
            r_rdata <= (w_code == ERR_OK && !r_write) ? slot.rd_data : '0;
            r_err   <= w_code;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// Self-checking bench for mmio_slot_ctrl with a behavioural slot model.
module tb_mmio_slot_ctrl;
  import mmio_pkg::*;

  localparam int unsigned NR  = 2;
  localparam int unsigned TMO = 16;

  localparam int SM_OK   = 0;
  localparam int SM_SLV  = 1;
  localparam int SM_DEC  = 2;
  localparam int SM_NONE = 3;
  localparam int SM_BOTH = 4;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [NR-1:0]  req;
  logic [NR-1:0]  req_write;
  logic [NR*8-1:0]  req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]  gnt;
  logic [NR-1:0]  rsp_valid;
  logic [31:0]    rsp_rdata;
  logic [1:0]     rsp_err;

  mmio_slot_ctrl_if slot_if ();

  mmio_slot_ctrl #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .slot      (slot_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slot model: responds on the second edge that sees chip_select, holds flags until transaction_completed.
  int          slot_mode;
  logic [31:0] slot_rdata;
  logic [31:0] out_ports;
  logic [1:0]  scnt;

  assign slot_if.rd_data = slot_rdata;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      scnt                 <= '0;
      slot_if.wr_done      <= 1'b0;
      slot_if.rd_done      <= 1'b0;
      slot_if.slave_error  <= 1'b0;
      slot_if.decode_error <= 1'b0;
      out_ports            <= '0;
    end else if (slot_if.transaction_completed) begin
      scnt                 <= '0;
      slot_if.wr_done      <= 1'b0;
      slot_if.rd_done      <= 1'b0;
      slot_if.slave_error  <= 1'b0;
      slot_if.decode_error <= 1'b0;
    end else if (slot_if.chip_select && scnt < 2'd2) begin
      scnt <= scnt + 2'd1;
      if (scnt == 2'd1) begin
        case (slot_mode)
          SM_OK: begin
            if (slot_if.write) begin
              slot_if.wr_done <= 1'b1;
              if (slot_if.addr == 8'h00) out_ports <= slot_if.wr_data;
            end else begin
              slot_if.rd_done <= 1'b1;
            end
          end
          SM_SLV:  slot_if.slave_error  <= 1'b1;
          SM_DEC:  slot_if.decode_error <= 1'b1;
          SM_BOTH: begin
            slot_if.rd_done     <= 1'b1;
            slot_if.slave_error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [7:0]  a;
    logic [31:0] wd;
    int          mode;
    logic [31:0] srd;
    int          lat;
    logic [31:0] erd;
    logic [1:0]  err;
  } vec_t;

  vec_t vt[7];

  task automatic do_reset();
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    arst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // One isolated access: grant in c0, strobes in c1, response at the expected latency.
  task automatic run_vec(input vec_t v);
    int          lat;
    bit          seen;
    logic [NR-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    @(posedge clk); #1;
    slot_mode  = v.mode;
    slot_rdata = v.srd;
    req        = '0;
    req[v.idx] = 1'b1;
    req_write[v.idx]        = v.wr;
    req_addr[v.idx*8 +: 8]  = v.a;
    req_wdata[v.idx*32 +: 32] = v.wd;
    @(negedge clk);
    chk("gnt_c0", gnt, oh);
    chk("cs_c0", slot_if.chip_select, 1'b0);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("cs_c1", slot_if.chip_select, 1'b1);
    chk("wr_rd_c1", {slot_if.write, slot_if.read}, {v.wr, ~v.wr});
    chk("addr_c1", slot_if.addr, v.a);
    chk("wdata_c1", slot_if.wr_data, v.wd);
    lat  = 1;
    seen = 0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != '0) seen = 1;
    end
    chk("rsp_latency", lat, v.lat);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_rdata", rsp_rdata, v.erd);
    chk("rsp_err", rsp_err, v.err);
    chk("tc_pulse", {slot_if.transaction_completed, slot_if.chip_select, slot_if.read, slot_if.write}, 4'b1000);
    @(negedge clk);
    chk("after_rsp", {slot_if.transaction_completed, rsp_valid}, '0);
    chk("slot_idle", {slot_if.rd_done, slot_if.wr_done, slot_if.slave_error, slot_if.decode_error}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov;
    int cnt;
    logic [NR-1:0] exp_g;
    slot_mode  = SM_OK;
    slot_rdata = '0;

    vt[0] = '{0, 1'b1, 8'h00, 32'h0000_0001, SM_OK,   32'hDEAD_BEEF, 4,  32'h0,         ERR_OK};
    vt[1] = '{1, 1'b0, 8'h18, 32'h0,         SM_OK,   32'h0000_0001, 4,  32'h0000_0001, ERR_OK};
    vt[2] = '{0, 1'b0, 8'h00, 32'h0,         SM_SLV,  32'hDEAD_BEEF, 4,  32'h0,         ERR_SLAVE};
    vt[3] = '{0, 1'b1, 8'h40, 32'h0000_0005, SM_DEC,  32'hDEAD_BEEF, 4,  32'h0,         ERR_DECODE};
    vt[4] = '{1, 1'b0, 8'h10, 32'h0,         SM_BOTH, 32'h0000_1234, 4,  32'h0,         ERR_SLAVE};
    vt[5] = '{0, 1'b0, 8'h08, 32'h0,         SM_NONE, 32'h0000_0055, 17, 32'h0,         ERR_TIMEOUT};
    vt[6] = '{1, 1'b0, 8'h04, 32'h0,         SM_OK,   32'hA5A5_0F0F, 4,  32'hA5A5_0F0F, ERR_OK};

    do_reset();
    @(negedge clk);
    chk("reset_outs", {gnt, rsp_valid, rsp_rdata, rsp_err, slot_if.chip_select, slot_if.read,
                       slot_if.write, slot_if.addr, slot_if.transaction_completed}, '0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i]);
      if (i == 0) chk("gpio_out0", out_ports[0], 1'b1);
    end

    // Reset asserted during the second ACCESS cycle.
    @(posedge clk); #1;
    slot_mode = SM_NONE;
    req = 2'b01; req_write = '0; req_addr[7:0] = 8'h08;
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    chk("mid_cs", slot_if.chip_select, 1'b1);
    arst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {gnt, rsp_valid, slot_if.chip_select, slot_if.read, slot_if.write,
                           slot_if.addr, slot_if.wr_data, slot_if.transaction_completed}, '0);
    @(negedge clk);
    arst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    chk("no_rsp_after_reset", cnt, 0);
    run_vec('{0, 1'b1, 8'h00, 32'h0000_0003, SM_OK, 32'h0, 4, 32'h0, ERR_OK});
    chk("gpio_out_post_reset", out_ports, 32'h3);

    // Held requests from both sides alternate starting at requester 0.
    do_reset();
    slot_mode = SM_OK;
    @(posedge clk); #1;
    req_write = '0;
    req_addr  = {8'h18, 8'h18};
    req = 2'b11;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      n = 0;
      while (gnt == '0 && n < 30) begin
        @(negedge clk);
        n++;
      end
      exp_g = (a % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", gnt, exp_g);
      chk("rr_cs_gap", slot_if.chip_select, 1'b0);
      n = 0;
      ov = 0;
      do begin
        @(negedge clk);
        n++;
        if (gnt != '0 && rsp_valid == '0) ov++;
      end while (rsp_valid == '0 && n < 30);
      chk("rr_rsp", rsp_valid, exp_g);
      chk("rr_no_overlap", ov, 0);
      chk("rr_gnt_in_rsp", gnt, '0);
      @(negedge clk);
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
